skid_buffer: RTL and testbench

Two-entry valid/ready skid buffer that registers both the forward path (out_valid/out_data) and the backward path (in_ready), so no combinational path crosses the block in either direction. It sits between pipeline stages wherever the downstream ready must be cut from the upstream timing path, complementing the forward-only pipeline stage. Full throughput of one transfer per cycle; one-cycle forward latency.

---
 rtl/skid_buffer.sv | 120 ++++++++++++
 tb/tb_skid_buffer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/skid_buffer.sv
// Two-entry valid/ready skid buffer with registered forward and backward paths.
// Optional stats counters are enabled by defining SKID_BUFFER_STATS_EN.
module skid_buffer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [15:0]      stall_cycles,
  output logic [15:0]      skid_hits
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] skid;
  logic             xfer_in;
  logic             xfer_out;

  assign xfer_in  = in_valid && in_ready;
  assign xfer_out = out_valid && out_ready;

  // in_ready is loaded with (next state != FULL) on every edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_data  <= '0;
      skid      <= '0;
      in_ready  <= 1'b0;
      occupancy <= 2'd0;
    end else if (flush) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      occupancy <= 2'd0;
    end else begin
      unique case (state)
        EMPTY: begin
          in_ready <= 1'b1;
          if (xfer_in) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            occupancy <= 2'd1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          in_ready <= 1'b1;
          unique case ({xfer_in, xfer_out})
            2'b11: out_data <= in_data;
            2'b10: begin
              skid      <= in_data;
              occupancy <= 2'd2;
              in_ready  <= 1'b0;
              state     <= FULL;
            end
            2'b01: begin
              out_valid <= 1'b0;
              occupancy <= 2'd0;
              state     <= EMPTY;
            end
            default: ;
          endcase
        end
        FULL: begin
          in_ready <= 1'b0;
          if (xfer_out) begin
            out_data  <= skid;
            occupancy <= 2'd1;
            in_ready  <= 1'b1;
            state     <= BUSY;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          occupancy <= 2'd0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

`ifdef SKID_BUFFER_STATS_EN
  logic skid_hit;

  assign skid_hit = !flush && (state == BUSY)
                    && xfer_in && !xfer_out;

  // counters survive flush; only rst clears them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      skid_hits    <= '0;
    end else begin
      if (out_valid && !out_ready
          && stall_cycles != 16'hFFFF)
        stall_cycles <= stall_cycles + 16'd1;
      if (skid_hit && skid_hits != 16'hFFFF)
        skid_hits <= skid_hits + 16'd1;
    end
  end
`else
  assign stall_cycles = '0;
  assign skid_hits    = '0;
`endif

endmodule

// File: tb/tb_skid_buffer.sv
// Self-checking bench for skid_buffer: directed vector table,
// queue-based reference model under random traffic, reset and stats checks.
module tb_skid_buffer;

`ifdef SKID_BUFFER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  occupancy;
  logic [15:0] stall_cycles;
  logic [15:0] skid_hits;

  skid_buffer #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .occupancy    (occupancy),
    .stall_cycles (stall_cycles),
    .skid_hits    (skid_hits)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int miss = 0;

  // reference model: a plain FIFO of at most two beats
  logic [31:0] q[$];
  bit          m_ir;
  int          m_stall;
  int          m_hits;

  typedef struct {
    logic        fl;
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        eov;
    logic [31:0] ed;
    logic [1:0]  eocc;
    logic        eir;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    vecs++;
    if (a !== e) begin
      miss++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ir    = 1'b0;
    m_stall = 0;
    m_hits  = 0;
  endtask

  task automatic step();
    int pre;
    bit xin;
    bit xout;
    pre  = q.size();
    xin  = in_valid && m_ir;
    xout = (pre > 0) && out_ready;
    @(posedge clk);
    #1;
    if (pre > 0 && !out_ready && m_stall < 65535)
      m_stall++;
    if (flush) begin
      q.delete();
    end else begin
      if (xout) void'(q.pop_front());
      if (xin) q.push_back(in_data);
      if (pre == 1 && q.size() == 2 && m_hits < 65535)
        m_hits++;
    end
    m_ir = (q.size() < 2);
  endtask

  task automatic chk_model(string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() > 0));
    chk({tag, ".occupancy"}, 32'(occupancy), 32'(q.size()));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(m_ir));
    if (q.size() > 0)
      chk({tag, ".out_data"}, out_data, q[0]);
  endtask

  task automatic chk_stats(string tag);
    chk({tag, ".stall_cycles"}, 32'(stall_cycles),
        STATS ? 32'(m_stall) : 32'd0);
    chk({tag, ".skid_hits"}, 32'(skid_hits),
        STATS ? 32'(m_hits) : 32'd0);
  endtask

  task automatic add(logic fl, logic iv, logic [31:0] d, logic ordy,
                     logic eov, logic [31:0] ed, logic [1:0] eocc,
                     logic eir);
    vec_t v;
    v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
    v.eov = eov; v.ed = ed; v.eocc = eocc; v.eir = eir;
    tbl.push_back(v);
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    model_reset();

    // streaming 1..8 then drain
    for (int k = 1; k <= 8; k++)
      add(0, 1, 32'(k), 1, 1, 32'(k), 2'd1, 1);
    add(0, 0, 0, 1, 0, 0, 2'd0, 1);
    // backpressure: A, B fill, C held off, then drain in order
    add(0, 1, 32'hA, 0, 1, 32'hA, 2'd1, 1);
    add(0, 1, 32'hB, 0, 1, 32'hA, 2'd2, 0);
    add(0, 1, 32'hC, 0, 1, 32'hA, 2'd2, 0);
    add(0, 1, 32'hC, 1, 1, 32'hB, 2'd1, 1);
    add(0, 1, 32'hC, 1, 1, 32'hC, 2'd1, 1);
    add(0, 0, 0, 1, 0, 0, 2'd0, 1);
    // flush while FULL discards the beat offered on the flush cycle
    add(0, 1, 32'h11, 0, 1, 32'h11, 2'd1, 1);
    add(0, 1, 32'h22, 0, 1, 32'h11, 2'd2, 0);
    add(1, 1, 32'h33, 0, 0, 0, 2'd0, 1);
    add(0, 0, 0, 1, 0, 0, 2'd0, 1);
    add(0, 1, 32'h44, 1, 1, 32'h44, 2'd1, 1);
    add(0, 0, 0, 1, 0, 0, 2'd0, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("rst.out_valid", 32'(out_valid), 0);
    chk("rst.in_ready", 32'(in_ready), 0);
    chk("rst.occupancy", 32'(occupancy), 0);
    chk("rst.out_data", out_data, 0);
    chk("rst.stall", 32'(stall_cycles), 0);
    chk("rst.hits", 32'(skid_hits), 0);

    rst = 1'b0;
    step();
    chk("release.in_ready", 32'(in_ready), 1);

    foreach (tbl[i]) begin
      string tag;
      tag       = $sformatf("vec%0d", i);
      flush     = tbl[i].fl;
      in_valid  = tbl[i].iv;
      in_data   = tbl[i].d;
      out_ready = tbl[i].ordy;
      step();
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(tbl[i].eov));
      chk({tag, ".occupancy"}, 32'(occupancy), 32'(tbl[i].eocc));
      chk({tag, ".in_ready"}, 32'(in_ready), 32'(tbl[i].eir));
      if (tbl[i].eov)
        chk({tag, ".out_data"}, out_data, tbl[i].ed);
    end
    flush = 1'b0;
    chk("table.skid_hits", 32'(skid_hits), STATS ? 32'd2 : 32'd0);
    chk_stats("table");

    for (int c = 0; c < 4000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = $urandom;
      flush     = ($urandom_range(0, 63) == 0);
      step();
      chk_model("rand");
    end
    flush = 1'b0;
    chk_stats("rand");

    // asynchronous reset while FULL
    in_valid  = 1'b1;
    out_ready = 1'b0;
    in_data   = 32'h5A5A;
    repeat (3) step();
    chk_model("prefull");
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst.out_valid", 32'(out_valid), 0);
    chk("arst.in_ready", 32'(in_ready), 0);
    chk("arst.occupancy", 32'(occupancy), 0);
    chk("arst.out_data", out_data, 0);
    chk_stats("arst");
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step();
    chk_model("arst.release");

    // long stall: one beat held with out_ready low
    in_valid  = 1'b1;
    in_data   = 32'h77;
    step();
    in_valid  = 1'b0;
`ifdef SKID_BUFFER_STATS_EN
    repeat (70000) step();
    chk("sat.stall", 32'(stall_cycles), 32'hFFFF);
`else
    repeat (200) step();
    chk("nostats.stall", 32'(stall_cycles), 0);
`endif
    chk_model("sat");
    chk_stats("sat");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
